// File: rtl/vanilla_sb_clear_gen_if.sv
// Completion-side bundle between the scoreboard-clear generator and its sources/consumers.
interface vanilla_sb_clear_gen_if #(
  parameter int data_width_p     = 32,
  parameter int reg_addr_width_p = 5,
  parameter int fifo_els_p       = 2
);
  localparam int cnt_w = $clog2(fifo_els_p + 1);

  logic                        remote_v_i;
  logic                        remote_float_i;
  logic [reg_addr_width_p-1:0] remote_id_i;
  logic [data_width_p-1:0]     remote_data_i;
  logic                        remote_ready_o;

  logic                        idiv_v_i;
  logic [reg_addr_width_p-1:0] idiv_id_i;
  logic [data_width_p-1:0]     idiv_data_i;
  logic                        idiv_yumi_o;

  logic                        fdiv_v_i;
  logic [reg_addr_width_p-1:0] fdiv_id_i;
  logic [data_width_p-1:0]     fdiv_data_i;
  logic                        fdiv_yumi_o;

  logic                        int_wb_free_i;
  logic                        float_wb_free_i;

  logic                        int_sb_clear_o;
  logic [reg_addr_width_p-1:0] int_sb_clear_id_o;
  logic [data_width_p-1:0]     int_wb_data_o;
  logic                        float_sb_clear_o;
  logic [reg_addr_width_p-1:0] float_sb_clear_id_o;
  logic [data_width_p-1:0]     float_wb_data_o;
  logic [cnt_w-1:0]            remote_count_o;

  modport slave (
    input  remote_v_i, remote_float_i, remote_id_i, remote_data_i,
    output remote_ready_o,
    input  idiv_v_i, idiv_id_i, idiv_data_i,
    output idiv_yumi_o,
    input  fdiv_v_i, fdiv_id_i, fdiv_data_i,
    output fdiv_yumi_o,
    input  int_wb_free_i, float_wb_free_i,
    output int_sb_clear_o, int_sb_clear_id_o, int_wb_data_o,
    output float_sb_clear_o, float_sb_clear_id_o, float_wb_data_o,
    output remote_count_o
  );

  modport master (
    output remote_v_i, remote_float_i, remote_id_i, remote_data_i,
    input  remote_ready_o,
    output idiv_v_i, idiv_id_i, idiv_data_i,
    input  idiv_yumi_o,
    output fdiv_v_i, fdiv_id_i, fdiv_data_i,
    input  fdiv_yumi_o,
    output int_wb_free_i, float_wb_free_i,
    input  int_sb_clear_o, int_sb_clear_id_o, int_wb_data_o,
    input  float_sb_clear_o, float_sb_clear_id_o, float_wb_data_o,
    input  remote_count_o
  );
endinterface

// File: rtl/vanilla_sb_clear_gen.sv
// Buffers remote responses and arbitrates them against idiv/fdiv completions onto the
// int and float writeback ports, producing registered scoreboard-clear pulses.
module vanilla_sb_clear_gen #(
  parameter int data_width_p     = 32,
  parameter int reg_addr_width_p = 5,
  parameter int fifo_els_p       = 2
) (
  input logic                  clk_i,
  input logic                  reset_n_i,
  vanilla_sb_clear_gen_if.slave sb
);
  localparam int ptr_w = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int cnt_w = $clog2(fifo_els_p + 1);
  localparam logic [cnt_w-1:0] full_c = cnt_w'(fifo_els_p);
  localparam logic [ptr_w-1:0] last_c = ptr_w'(fifo_els_p - 1);

  logic                        mem_float [fifo_els_p];
  logic [reg_addr_width_p-1:0] mem_id    [fifo_els_p];
  logic [data_width_p-1:0]     mem_data  [fifo_els_p];

  logic [ptr_w-1:0] rd_ptr, wr_ptr;
  logic [cnt_w-1:0] count;
  logic             int_rr, flt_rr;

  logic full, enq, deq, head_v, head_float;
  logic int_rem_c, flt_rem_c;
  logic int_gnt_rem, int_gnt_div, flt_gnt_rem, flt_gnt_div;
  logic int_contend, flt_contend;

  logic                        int_clear_p1, flt_clear_p1;
  logic [reg_addr_width_p-1:0] int_id_p1, flt_id_p1;
  logic [data_width_p-1:0]     int_data_p1, flt_data_p1;

  assign full       = (count == full_c);
  assign enq        = sb.remote_v_i & ~full;
  assign head_v     = (count != '0);
  assign head_float = mem_float[rd_ptr];
  // The head is owned by exactly one port, so a float head stalls younger int responses.
  assign int_rem_c  = head_v & ~head_float;
  assign flt_rem_c  = head_v & head_float;

  assign int_contend = sb.int_wb_free_i & int_rem_c & sb.idiv_v_i;
  assign flt_contend = sb.float_wb_free_i & flt_rem_c & sb.fdiv_v_i;

  always_comb begin
    int_gnt_rem = 1'b0;
    int_gnt_div = 1'b0;
    flt_gnt_rem = 1'b0;
    flt_gnt_div = 1'b0;
    if (sb.int_wb_free_i) begin
      if (int_contend) begin
        int_gnt_div = int_rr;
        int_gnt_rem = ~int_rr;
      end else begin
        int_gnt_rem = int_rem_c;
        int_gnt_div = sb.idiv_v_i;
      end
    end
    if (sb.float_wb_free_i) begin
      if (flt_contend) begin
        flt_gnt_div = flt_rr;
        flt_gnt_rem = ~flt_rr;
      end else begin
        flt_gnt_rem = flt_rem_c;
        flt_gnt_div = sb.fdiv_v_i;
      end
    end
  end

  assign deq = int_gnt_rem | flt_gnt_rem;

  assign sb.remote_ready_o = ~full;
  assign sb.remote_count_o = count;
  // Yumi must not leak a consume while reset is held, even though grant logic is combinational.
  assign sb.idiv_yumi_o    = int_gnt_div & reset_n_i;
  assign sb.fdiv_yumi_o    = flt_gnt_div & reset_n_i;

  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_float[wr_ptr] <= sb.remote_float_i;
      mem_id[wr_ptr]    <= sb.remote_id_i;
      mem_data[wr_ptr]  <= sb.remote_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      int_rr <= 1'b0;
      flt_rr <= 1'b0;
    end else begin
      if (enq) wr_ptr <= (wr_ptr == last_c) ? '0 : wr_ptr + ptr_w'(1);
      if (deq) rd_ptr <= (rd_ptr == last_c) ? '0 : rd_ptr + ptr_w'(1);
      case ({enq, deq})
        2'b10:   count <= count + cnt_w'(1);
        2'b01:   count <= count - cnt_w'(1);
        default: count <= count;
      endcase
      int_rr <= int_rr ^ int_contend;
      flt_rr <= flt_rr ^ flt_contend;
    end
  end

  // p1: registered writeback/clear stage, one cycle after grant
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      int_clear_p1 <= 1'b0;
      int_id_p1    <= '0;
      int_data_p1  <= '0;
      flt_clear_p1 <= 1'b0;
      flt_id_p1    <= '0;
      flt_data_p1  <= '0;
    end else begin
      int_clear_p1 <= int_gnt_rem | int_gnt_div;
      flt_clear_p1 <= flt_gnt_rem | flt_gnt_div;
      if (int_gnt_div) begin
        int_id_p1   <= sb.idiv_id_i;
        int_data_p1 <= sb.idiv_data_i;
      end else if (int_gnt_rem) begin
        int_id_p1   <= mem_id[rd_ptr];
        int_data_p1 <= mem_data[rd_ptr];
      end
      if (flt_gnt_div) begin
        flt_id_p1   <= sb.fdiv_id_i;
        flt_data_p1 <= sb.fdiv_data_i;
      end else if (flt_gnt_rem) begin
        flt_id_p1   <= mem_id[rd_ptr];
        flt_data_p1 <= mem_data[rd_ptr];
      end
    end
  end

  assign sb.int_sb_clear_o      = int_clear_p1;
  assign sb.int_sb_clear_id_o   = int_id_p1;
  assign sb.int_wb_data_o       = int_data_p1;
  assign sb.float_sb_clear_o    = flt_clear_p1;
  assign sb.float_sb_clear_id_o = flt_id_p1;
  assign sb.float_wb_data_o     = flt_data_p1;
endmodule

// File: tb/tb_vanilla_sb_clear_gen.sv
// Bench for vanilla_sb_clear_gen: cycle table plus hand sequences, with per-port clear scoreboards.
module tb_vanilla_sb_clear_gen;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vanilla_sb_clear_gen_if #(.data_width_p(32), .reg_addr_width_p(5), .fifo_els_p(2)) bus ();

  vanilla_sb_clear_gen #(.data_width_p(32), .reg_addr_width_p(5), .fifo_els_p(2)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .sb        (bus.slave)
  );

  typedef struct {
    logic        rv, rf;
    logic [4:0]  rid;
    logic [31:0] rdata;
    logic        iv;
    logic [4:0]  iid;
    logic        fv;
    logic [4:0]  fid;
    logic        ifree, ffree;
    logic        e_rdy;
    logic [1:0]  e_cnt;
    logic        e_iy, e_fy, e_ic;
    logic [4:0]  e_iid;
    logic        e_fc;
    logic [4:0]  e_fid;
  } vec_t;

  typedef struct {
    logic [4:0]  id;
    logic [31:0] data;
  } exp_t;

  vec_t vecs[$];
  exp_t int_q[$];
  exp_t flt_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic mon_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rv, input logic rf, input logic [4:0] rid,
                              input logic [31:0] rdata, input logic iv, input logic [4:0] iid,
                              input logic fv, input logic [4:0] fid, input logic ifree,
                              input logic ffree, input logic e_rdy, input logic [1:0] e_cnt,
                              input logic e_iy, input logic e_fy, input logic e_ic,
                              input logic [4:0] e_iid, input logic e_fc, input logic [4:0] e_fid);
    vec_t v;
    v.rv = rv; v.rf = rf; v.rid = rid; v.rdata = rdata;
    v.iv = iv; v.iid = iid; v.fv = fv; v.fid = fid;
    v.ifree = ifree; v.ffree = ffree;
    v.e_rdy = e_rdy; v.e_cnt = e_cnt; v.e_iy = e_iy; v.e_fy = e_fy;
    v.e_ic = e_ic; v.e_iid = e_iid; v.e_fc = e_fc; v.e_fid = e_fid;
    return v;
  endfunction

  function automatic exp_t ex(input logic [4:0] id, input logic [31:0] data);
    exp_t e;
    e.id = id; e.data = data;
    return e;
  endfunction

  task automatic drive_remote(input logic v, input logic f, input logic [4:0] id, input logic [31:0] d);
    bus.remote_v_i     = v;
    bus.remote_float_i = f;
    bus.remote_id_i    = id;
    bus.remote_data_i  = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every clear pulse must match the next expected completion for that port.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.int_sb_clear_o) begin
        if (int_q.size() == 0) begin
          chk("int_clear_unexpected", 32'(bus.int_sb_clear_id_o), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = int_q.pop_front();
          chk("sb_int_id", 32'(bus.int_sb_clear_id_o), 32'(e.id));
          chk("sb_int_data", bus.int_wb_data_o, e.data);
        end
      end
      if (bus.float_sb_clear_o) begin
        if (flt_q.size() == 0) begin
          chk("float_clear_unexpected", 32'(bus.float_sb_clear_id_o), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = flt_q.pop_front();
          chk("sb_float_id", 32'(bus.float_sb_clear_id_o), 32'(e.id));
          chk("sb_float_data", bus.float_wb_data_o, e.data);
        end
      end
    end
  end

  initial begin
    drive_remote(1'b0, 1'b0, 5'd0, 32'd0);
    bus.idiv_v_i = 1'b0; bus.idiv_id_i = '0; bus.idiv_data_i = '0;
    bus.fdiv_v_i = 1'b0; bus.fdiv_id_i = '0; bus.fdiv_data_i = '0;
    bus.int_wb_free_i = 1'b0; bus.float_wb_free_i = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_count", 32'(bus.remote_count_o), 32'd0);
    chk("rst_ready", 32'(bus.remote_ready_o), 32'd1);
    chk("rst_int_clear", 32'(bus.int_sb_clear_o), 32'd0);
    chk("rst_float_clear", 32'(bus.float_sb_clear_o), 32'd0);
    chk("rst_int_id", 32'(bus.int_sb_clear_id_o), 32'd0);
    chk("rst_int_data", bus.int_wb_data_o, 32'd0);
    chk("rst_float_data", bus.float_wb_data_o, 32'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    step();

    //        rv rf rid  rdata         iv iid fv fid if ff | rdy cnt iy fy ic iid fc fid
    vecs.push_back(mk(0,0,5'd0, 32'h0,        0,5'd0,0,5'd0, 1,1, 1,2'd0,0,0,0,5'd0,0,5'd0));
    vecs.push_back(mk(1,0,5'd5, 32'hDEADBEEF, 0,5'd0,0,5'd0, 1,1, 1,2'd0,0,0,0,5'd0,0,5'd0));
    vecs.push_back(mk(0,0,5'd0, 32'h0,        0,5'd0,0,5'd0, 1,1, 1,2'd1,0,0,0,5'd0,0,5'd0));
    vecs.push_back(mk(0,0,5'd0, 32'h0,        0,5'd0,0,5'd0, 1,1, 1,2'd0,0,0,1,5'd5,0,5'd0));
    vecs.push_back(mk(0,0,5'd0, 32'h0,        0,5'd0,0,5'd0, 1,1, 1,2'd0,0,0,0,5'd5,0,5'd0));
    vecs.push_back(mk(1,0,5'd3, 32'h33,       0,5'd0,0,5'd0, 0,1, 1,2'd0,0,0,0,5'd5,0,5'd0));
    vecs.push_back(mk(1,0,5'd3, 32'h34,       0,5'd0,0,5'd0, 0,1, 1,2'd1,0,0,0,5'd5,0,5'd0));
    vecs.push_back(mk(0,0,5'd0, 32'h0,        1,5'd7,0,5'd0, 1,1, 0,2'd2,0,0,0,5'd5,0,5'd0));
    vecs.push_back(mk(0,0,5'd0, 32'h0,        1,5'd7,0,5'd0, 1,1, 1,2'd1,1,0,1,5'd3,0,5'd0));
    vecs.push_back(mk(0,0,5'd0, 32'h0,        1,5'd7,0,5'd0, 1,1, 1,2'd1,0,0,1,5'd7,0,5'd0));
    vecs.push_back(mk(0,0,5'd0, 32'h0,        1,5'd7,0,5'd0, 1,1, 1,2'd0,1,0,1,5'd3,0,5'd0));
    vecs.push_back(mk(1,0,5'd3, 32'h35,       0,5'd0,0,5'd0, 0,1, 1,2'd0,0,0,1,5'd7,0,5'd0));
    vecs.push_back(mk(0,0,5'd0, 32'h0,        1,5'd7,0,5'd0, 1,1, 1,2'd1,1,0,0,5'd7,0,5'd0));
    vecs.push_back(mk(0,0,5'd0, 32'h0,        0,5'd0,0,5'd0, 1,1, 1,2'd1,0,0,1,5'd7,0,5'd0));
    vecs.push_back(mk(0,0,5'd0, 32'h0,        0,5'd0,0,5'd0, 1,1, 1,2'd0,0,0,1,5'd3,0,5'd0));
    vecs.push_back(mk(0,0,5'd0, 32'h0,        0,5'd0,0,5'd0, 1,1, 1,2'd0,0,0,0,5'd3,0,5'd0));
    vecs.push_back(mk(1,0,5'd9, 32'h99,       0,5'd0,0,5'd0, 1,1, 1,2'd0,0,0,0,5'd3,0,5'd0));
    vecs.push_back(mk(0,0,5'd0, 32'h0,        0,5'd0,1,5'd11,1,1, 1,2'd1,0,1,0,5'd3,0,5'd0));
    vecs.push_back(mk(0,0,5'd0, 32'h0,        0,5'd0,0,5'd0, 1,1, 1,2'd0,0,0,1,5'd9,1,5'd11));
    vecs.push_back(mk(0,0,5'd0, 32'h0,        0,5'd0,0,5'd0, 1,1, 1,2'd0,0,0,0,5'd9,0,5'd11));
    vecs.push_back(mk(1,0,5'd0, 32'h0,        0,5'd0,0,5'd0, 1,1, 1,2'd0,0,0,0,5'd9,0,5'd11));
    vecs.push_back(mk(0,0,5'd0, 32'h0,        0,5'd0,0,5'd0, 1,1, 1,2'd1,0,0,0,5'd9,0,5'd11));
    vecs.push_back(mk(0,0,5'd0, 32'h0,        0,5'd0,0,5'd0, 1,1, 1,2'd0,0,0,1,5'd0,0,5'd11));
    vecs.push_back(mk(0,0,5'd0, 32'h0,        0,5'd0,0,5'd0, 1,1, 1,2'd0,0,0,0,5'd0,0,5'd11));

    int_q.push_back(ex(5'd5, 32'hDEADBEEF));
    int_q.push_back(ex(5'd3, 32'h33));
    int_q.push_back(ex(5'd7, 32'h1007));
    int_q.push_back(ex(5'd3, 32'h34));
    int_q.push_back(ex(5'd7, 32'h1007));
    int_q.push_back(ex(5'd7, 32'h1007));
    int_q.push_back(ex(5'd3, 32'h35));
    int_q.push_back(ex(5'd9, 32'h99));
    int_q.push_back(ex(5'd0, 32'h0));
    flt_q.push_back(ex(5'd11, 32'h200B));

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      drive_remote(v.rv, v.rf, v.rid, v.rdata);
      bus.idiv_v_i = v.iv; bus.idiv_id_i = v.iid; bus.idiv_data_i = 32'h1000 | 32'(v.iid);
      bus.fdiv_v_i = v.fv; bus.fdiv_id_i = v.fid; bus.fdiv_data_i = 32'h2000 | 32'(v.fid);
      bus.int_wb_free_i = v.ifree; bus.float_wb_free_i = v.ffree;
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), 32'(bus.remote_ready_o), 32'(v.e_rdy));
      chk($sformatf("v%0d_count", i), 32'(bus.remote_count_o), 32'(v.e_cnt));
      chk($sformatf("v%0d_idiv_yumi", i), 32'(bus.idiv_yumi_o), 32'(v.e_iy));
      chk($sformatf("v%0d_fdiv_yumi", i), 32'(bus.fdiv_yumi_o), 32'(v.e_fy));
      chk($sformatf("v%0d_int_clear", i), 32'(bus.int_sb_clear_o), 32'(v.e_ic));
      chk($sformatf("v%0d_int_id", i), 32'(bus.int_sb_clear_id_o), 32'(v.e_iid));
      chk($sformatf("v%0d_float_clear", i), 32'(bus.float_sb_clear_o), 32'(v.e_fc));
      chk($sformatf("v%0d_float_id", i), 32'(bus.float_sb_clear_id_o), 32'(v.e_fid));
      step();
    end
    bus.idiv_v_i = 1'b0; bus.fdiv_v_i = 1'b0;

    // Fill: three back-to-back remote responses into a two-entry buffer with int port busy
    int_q.push_back(ex(5'd21, 32'hA1));
    int_q.push_back(ex(5'd22, 32'hA2));
    int_q.push_back(ex(5'd23, 32'hA3));
    bus.int_wb_free_i = 1'b0;
    drive_remote(1'b1, 1'b0, 5'd21, 32'hA1);
    @(negedge clk); chk("fill_a_ready", 32'(bus.remote_ready_o), 32'd1);
    step();
    drive_remote(1'b1, 1'b0, 5'd22, 32'hA2);
    @(negedge clk); chk("fill_b_count", 32'(bus.remote_count_o), 32'd1);
    step();
    drive_remote(1'b1, 1'b0, 5'd23, 32'hA3);
    @(negedge clk);
    chk("fill_c_ready", 32'(bus.remote_ready_o), 32'd0);
    chk("fill_c_count", 32'(bus.remote_count_o), 32'd2);
    step();
    bus.int_wb_free_i = 1'b1;
    @(negedge clk);
    chk("fill_d_ready", 32'(bus.remote_ready_o), 32'd0);
    chk("fill_d_clear", 32'(bus.int_sb_clear_o), 32'd0);
    step();
    @(negedge clk);
    chk("fill_e_ready", 32'(bus.remote_ready_o), 32'd1);
    chk("fill_e_id", 32'(bus.int_sb_clear_id_o), 32'd21);
    step();
    drive_remote(1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("fill_f_count", 32'(bus.remote_count_o), 32'd1);
    chk("fill_f_id", 32'(bus.int_sb_clear_id_o), 32'd22);
    step();
    @(negedge clk);
    chk("fill_g_id", 32'(bus.int_sb_clear_id_o), 32'd23);
    chk("fill_g_count", 32'(bus.remote_count_o), 32'd0);
    step();
    @(negedge clk); chk("fill_h_clear", 32'(bus.int_sb_clear_o), 32'd0);
    step();

    // Ordering: float head blocks a younger int response until the float port frees up
    flt_q.push_back(ex(5'd2, 32'hF2));
    int_q.push_back(ex(5'd4, 32'h44));
    bus.float_wb_free_i = 1'b0;
    drive_remote(1'b1, 1'b1, 5'd2, 32'hF2);
    step();
    drive_remote(1'b1, 1'b0, 5'd4, 32'h44);
    step();
    drive_remote(1'b0, 1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("ord_wait%0d_int_clear", k), 32'(bus.int_sb_clear_o), 32'd0);
      chk($sformatf("ord_wait%0d_count", k), 32'(bus.remote_count_o), 32'd2);
      step();
    end
    bus.float_wb_free_i = 1'b1;
    @(negedge clk); chk("ord_grant_float_clear", 32'(bus.float_sb_clear_o), 32'd0);
    step();
    @(negedge clk);
    chk("ord_float_clear", 32'(bus.float_sb_clear_o), 32'd1);
    chk("ord_float_id", 32'(bus.float_sb_clear_id_o), 32'd2);
    chk("ord_int_not_yet", 32'(bus.int_sb_clear_o), 32'd0);
    step();
    @(negedge clk);
    chk("ord_int_clear", 32'(bus.int_sb_clear_o), 32'd1);
    chk("ord_int_id", 32'(bus.int_sb_clear_id_o), 32'd4);
    chk("ord_float_done", 32'(bus.float_sb_clear_o), 32'd0);
    step();

    // Mid-operation reset with two buffered entries
    bus.int_wb_free_i = 1'b0;
    drive_remote(1'b1, 1'b0, 5'd12, 32'hC1);
    step();
    drive_remote(1'b1, 1'b0, 5'd13, 32'hC2);
    step();
    drive_remote(1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("mrst_pre_count", 32'(bus.remote_count_o), 32'd2);
    reset_n = 1'b0;
    bus.int_wb_free_i = 1'b1;
    bus.idiv_v_i = 1'b1; bus.idiv_id_i = 5'd6; bus.idiv_data_i = 32'h1006;
    #1;
    chk("mrst_count", 32'(bus.remote_count_o), 32'd0);
    chk("mrst_ready", 32'(bus.remote_ready_o), 32'd1);
    chk("mrst_idiv_yumi", 32'(bus.idiv_yumi_o), 32'd0);
    chk("mrst_int_id", 32'(bus.int_sb_clear_id_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    bus.idiv_v_i = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("mrst_post%0d_int_clear", k), 32'(bus.int_sb_clear_o), 32'd0);
      chk($sformatf("mrst_post%0d_float_clear", k), 32'(bus.float_sb_clear_o), 32'd0);
      chk($sformatf("mrst_post%0d_count", k), 32'(bus.remote_count_o), 32'd0);
      step();
    end

    chk("int_sb_leftover", 32'(int_q.size()), 32'd0);
    chk("float_sb_leftover", 32'(flt_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
